// File: rtl/riscv_crypto_aes_pkg.sv
// Shared AES helpers for the crypto FU: FSM/op encodings, rcon table,
// byte-select helper, GF(2^8) arithmetic, sbox and MixColumns functions.
package riscv_crypto_aes_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SUB, ST_FIN} saes_state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_KS1, OP_KS2, OP_IMIX, OP_ENCS, OP_ENCSM, OP_DECS, OP_DECSM
    } saes_op_t;

    function automatic bit s_legal(input int s);
        return (s == 2) || (s == 4) || (s == 8);
    endfunction

    function automatic logic [7:0] by(input logic [127:0] v, input int i);
        return v[8*i +: 8];
    endfunction

    // Round constants for rnum 0..9; 0xA..0xF carry no constant.
    function automatic logic [7:0] rcon(input logic [3:0] rnum);
        case (rnum)
            4'h0: return 8'h01;
            4'h1: return 8'h02;
            4'h2: return 8'h04;
            4'h3: return 8'h08;
            4'h4: return 8'h10;
            4'h5: return 8'h20;
            4'h6: return 8'h40;
            4'h7: return 8'h80;
            4'h8: return 8'h1b;
            4'h9: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 by square-and-multiply; maps 0 to 0 as the sbox requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // Byte 0 of a column sits in bits [7:0] (row 0).
    function automatic logic [31:0] mix_enc(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = c;
        return {xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3),
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
    endfunction

    function automatic logic [31:0] mix_dec(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = c;
        return {gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09)};
    endfunction

endpackage

// File: rtl/riscv_crypto_fu_saes64_lanes.sv
// S forward (and optionally S inverse) sbox lanes fed from one S-byte
// chunk of the pre-permuted 8-byte source vector.
module riscv_crypto_fu_saes64_lanes #(
    parameter int S      = 8,
    parameter bit DEC_EN = 1'b1
) (
    input  logic [63:0]    src,
    input  logic [2:0]     chunk,
    output logic [8*S-1:0] fwd_out,
    output logic [8*S-1:0] inv_out
);
    import riscv_crypto_aes_pkg::*;

    logic [8*S-1:0] sel;

    // Pick the chunk of source bytes these lanes work on this cycle.
    always_comb sel = (8*S)'(src >> (int'(chunk) * 8 * S));

    for (genvar i = 0; i < S; i++) begin : g_lane
        // Forward sbox lane.
        assign fwd_out[8*i +: 8] = fwd_sbox(sel[8*i +: 8]);
        if (DEC_EN) begin : g_inv
            // Inverse sbox lane, only built when decryption is enabled.
            assign inv_out[8*i +: 8] = inv_sbox(sel[8*i +: 8]);
        end else begin : g_noinv
            // No inverse lane without decryption support.
            assign inv_out[8*i +: 8] = 8'h00;
        end
    end

endmodule

// File: rtl/riscv_crypto_fu_saes64_iter.sv
// Multi-cycle RV64 scalar AES unit: the sbox lanes are time-shared over
// the 8 result bytes; mix/xor/replication is applied once in FIN.
//
// state | meaning
// IDLE  | waiting for valid; on accept latches operands and does chunk 0
// SUB   | substituting chunk cnt from latched operands into the buffer
// FIN   | result presented on rd with ready for one cycle
module riscv_crypto_fu_saes64_iter
    import riscv_crypto_aes_pkg::*;
#(
    parameter bit SAES_DEC_EN   = 1'b1,
    parameter int SAES64_SBOXES = 8
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic [63:0] rs1,
    input  logic [63:0] rs2,
    input  logic [3:0]  enc_rcon,
    input  logic        op_saes64_ks1,
    input  logic        op_saes64_ks2,
    input  logic        op_saes64_imix,
    input  logic        op_saes64_encs,
    input  logic        op_saes64_encsm,
    input  logic        op_saes64_decs,
    input  logic        op_saes64_decsm,
    output logic [63:0] rd,
    output logic        ready
);
    localparam int S       = SAES64_SBOXES;
    localparam int NCH_ENC = 8 / S;
    localparam int NCH_KS1 = (4 + S - 1) / S;

    if (!s_legal(S)) begin : g_bad_sboxes
        $error("SAES64_SBOXES must be 2, 4 or 8");
    end

    saes_state_t state_q;
    saes_op_t    op_q, op_in, cur_op;
    logic [2:0]  cnt_q, chunk;
    logic [63:0] rs1_q, rs2_q, buf_q, buf_d, cur_rs1, cur_rs2, src, fin;
    logic [63:0] mix_e, mix_d, imix_src;
    logic [3:0]  rnum_q, cur_rnum;
    logic [127:0] st;
    logic [31:0] w, ks1_r, ks2_lo;
    logic [8*S-1:0] fwd_out, inv_out, lane_out;
    logic        in_idle;

    function automatic logic [2:0] chunks_of(input saes_op_t op);
        case (op)
            OP_ENCS, OP_ENCSM, OP_DECS, OP_DECSM: return 3'(NCH_ENC);
            OP_KS1:                              return 3'(NCH_KS1);
            default:                             return 3'd0;
        endcase
    endfunction

    // Decode the one-hot op; disabled decrypt ops fall back to a zero result.
    always_comb begin
        op_in = OP_NONE;
        if (op_saes64_ks1)                       op_in = OP_KS1;
        else if (op_saes64_ks2)                  op_in = OP_KS2;
        else if (op_saes64_imix  && SAES_DEC_EN) op_in = OP_IMIX;
        else if (op_saes64_encs)                 op_in = OP_ENCS;
        else if (op_saes64_encsm)                op_in = OP_ENCSM;
        else if (op_saes64_decs  && SAES_DEC_EN) op_in = OP_DECS;
        else if (op_saes64_decsm && SAES_DEC_EN) op_in = OP_DECSM;
    end

    // Chunk 0 comes straight from the live inputs, later chunks from the latches.
    always_comb begin
        in_idle  = (state_q == ST_IDLE);
        cur_op   = in_idle ? op_in    : op_q;
        cur_rs1  = in_idle ? rs1      : rs1_q;
        cur_rs2  = in_idle ? rs2      : rs2_q;
        cur_rnum = in_idle ? enc_rcon : rnum_q;
        chunk    = in_idle ? 3'd0     : cnt_q;
    end

    // Byte permutation feeding the lanes: (Inv)ShiftRows for cols 0,1 or the ks1 word.
    always_comb begin
        st = {cur_rs2, cur_rs1};
        w  = cur_rs1[63:32];
        if (cur_rnum != 4'hA) w = {w[7:0], w[31:8]};
        src = {w, w};
        if (cur_op == OP_ENCS || cur_op == OP_ENCSM) begin
            for (int j = 0; j < 8; j++)
                src[8*j +: 8] = by(st, 4 * (((j / 4) + (j % 4)) % 4) + (j % 4));
        end else if (cur_op == OP_DECS || cur_op == OP_DECSM) begin
            for (int j = 0; j < 8; j++)
                src[8*j +: 8] = by(st, 4 * (((j / 4) - (j % 4) + 4) % 4) + (j % 4));
        end
    end

    riscv_crypto_fu_saes64_lanes #(.S(S), .DEC_EN(SAES_DEC_EN)) u_lanes (
        .src     (src),
        .chunk   (chunk),
        .fwd_out (fwd_out),
        .inv_out (inv_out)
    );

    // Merge this cycle's substituted chunk into the buffer.
    always_comb begin
        lane_out = (cur_op == OP_DECS || cur_op == OP_DECSM) ? inv_out : fwd_out;
        buf_d    = buf_q;
        for (int c = 0; c < NCH_ENC; c++)
            if (chunk == c[2:0]) buf_d[c*8*S +: 8*S] = lane_out;
    end

    // Sequencer: accept, walk the chunks, present, and abort when valid drops.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            buf_q   <= 64'd0;
            rs1_q   <= 64'd0;
            rs2_q   <= 64'd0;
            rnum_q  <= 4'd0;
            op_q    <= OP_NONE;
        end else begin
            case (state_q)
                ST_IDLE: if (valid) begin
                    rs1_q  <= rs1;
                    rs2_q  <= rs2;
                    rnum_q <= enc_rcon;
                    op_q   <= op_in;
                    buf_q  <= buf_d;
                    if (chunks_of(op_in) <= 3'd1) begin
                        state_q <= ST_FIN;
                    end else begin
                        state_q <= ST_SUB;
                        cnt_q   <= 3'd1;
                    end
                end
                ST_SUB: if (!valid) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 3'd0;
                end else begin
                    buf_q <= buf_d;
                    if (cnt_q == chunks_of(op_q) - 3'd1) begin
                        state_q <= ST_FIN;
                        cnt_q   <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Final result formation; rd is forced to zero unless ready.
    always_comb begin
        imix_src = (op_q == OP_IMIX) ? rs1_q : buf_q;
        mix_e    = {mix_enc(buf_q[63:32]), mix_enc(buf_q[31:0])};
        mix_d    = {mix_dec(imix_src[63:32]), mix_dec(imix_src[31:0])};
        ks1_r    = buf_q[31:0] ^ {24'd0, rcon(rnum_q)};
        ks2_lo   = rs1_q[63:32] ^ rs2_q[63:32];
        case (op_q)
            OP_KS1:            fin = {ks1_r, ks1_r};
            OP_KS2:            fin = {ks2_lo ^ rs2_q[31:0], ks2_lo};
            OP_IMIX, OP_DECSM: fin = mix_d;
            OP_ENCSM:          fin = mix_e;
            OP_ENCS, OP_DECS:  fin = buf_q;
            default:           fin = 64'd0;
        endcase
        ready = (state_q == ST_FIN) && valid;
        rd    = ready ? fin : 64'd0;
    end

endmodule

// File: tb/tb_riscv_crypto_fu_saes64_iter.sv
// Directed bench for the iterative saes64 unit: op vectors, latencies,
// aborts, reset, and a FIPS-197 AES-128 round trip built from the ops.
module tb_riscv_crypto_fu_saes64_iter;
    localparam int S_P    = 2;
    localparam bit DEC_EN = 1'b1;
    localparam int N      = 8 / S_P;
    localparam int LAT_KS1 = (4 / S_P > 1) ? 4 / S_P : 1;

    localparam int OPI_NONE = -1, OPI_KS1 = 0, OPI_KS2 = 1, OPI_IMIX = 2,
                   OPI_ENCS = 3, OPI_ENCSM = 4, OPI_DECS = 5, OPI_DECSM = 6;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        valid = 1'b0;
    logic [63:0] rs1 = 64'd0, rs2 = 64'd0;
    logic [3:0]  enc_rcon = 4'd0;
    logic [6:0]  op_vec = 7'd0;
    logic [63:0] rd;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;
    logic ready_q = 1'b0;

    riscv_crypto_fu_saes64_iter #(.SAES_DEC_EN(DEC_EN), .SAES64_SBOXES(S_P)) dut (
        .g_clk           (g_clk),
        .g_resetn        (g_resetn),
        .valid           (valid),
        .rs1             (rs1),
        .rs2             (rs2),
        .enc_rcon        (enc_rcon),
        .op_saes64_ks1   (op_vec[0]),
        .op_saes64_ks2   (op_vec[1]),
        .op_saes64_imix  (op_vec[2]),
        .op_saes64_encs  (op_vec[3]),
        .op_saes64_encsm (op_vec[4]),
        .op_saes64_decs  (op_vec[5]),
        .op_saes64_decsm (op_vec[6]),
        .rd              (rd),
        .ready           (ready)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output properties checked every cycle outside reset.
    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (!ready) chk("rd_zero_when_not_ready", rd, 64'd0);
            if (ready_q) chk("ready_not_back_to_back", {63'd0, ready}, 64'd0);
        end
        ready_q = ready && g_resetn;
    end

    function automatic logic [63:0] swap(input logic [63:0] x);
        return {x[31:0], x[63:32]};
    endfunction

    // Called just after a posedge; returns just after the posedge ending FIN.
    task automatic run_op(input int opi, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] rn, output logic [63:0] res, output int lat);
        op_vec   = (opi < 0) ? 7'd0 : 7'(1 << opi);
        rs1      = a;
        rs2      = b;
        enc_rcon = rn;
        valid    = 1'b1;
        lat      = 0;
        do begin
            @(posedge g_clk);
            @(negedge g_clk);
            lat++;
        end while (!ready && lat < 20);
        res = rd;
        if (!ready) lat = -1;
        @(posedge g_clk);
        #1;
        valid  = 1'b0;
        op_vec = 7'd0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge g_clk);
            #1;
        end
    endtask

    logic [63:0] res, t, lo, hi, s_lo, s_hi, d_lo, d_hi, i_lo, i_hi;
    logic [63:0] rk_lo [0:10];
    logic [63:0] rk_hi [0:10];
    int lat;
    int seen;

    initial begin
        repeat (3) @(negedge g_clk);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_rd", rd, 64'd0);
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        idle_cycles(1);

        run_op(OPI_ENCS, 64'd0, 64'd0, 4'd0, res, lat);
        chk("encs_zero", res, 64'h6363636363636363);
        chk("encs_zero_lat", 64'(lat), 64'(N));
        run_op(OPI_ENCSM, 64'd0, 64'd0, 4'd0, res, lat);
        chk("encsm_zero", res, 64'h6363636363636363);
        chk("encsm_zero_lat", 64'(lat), 64'(N));
        idle_cycles(1);
        run_op(OPI_DECS, 64'd0, 64'd0, 4'd0, res, lat);
        chk("decs_zero", res, DEC_EN ? 64'h5252525252525252 : 64'd0);
        chk("decs_zero_lat", 64'(lat), DEC_EN ? 64'(N) : 64'd1);
        run_op(OPI_KS1, 64'd0, 64'd0, 4'h0, res, lat);
        chk("ks1_rnum0", res, 64'h6363636263636362);
        chk("ks1_rnum0_lat", 64'(lat), 64'(LAT_KS1));
        run_op(OPI_KS1, 64'd0, 64'd0, 4'hA, res, lat);
        chk("ks1_rnumA", res, 64'h6363636363636363);
        run_op(OPI_KS2, 64'h1_00000000, 64'h2_00000003, 4'd0, res, lat);
        chk("ks2_vec", res, 64'h0000000000000003);
        chk("ks2_lat", 64'(lat), 64'd1);
        run_op(OPI_NONE, 64'h1234, 64'h5678, 4'd0, res, lat);
        chk("no_op_rd", res, 64'd0);
        chk("no_op_lat", 64'(lat), 64'd1);
        run_op(OPI_IMIX, 64'h9d58dc9f_bca14d8e, 64'd0, 4'd0, res, lat);
        chk("imix_vec", res, DEC_EN ? 64'h5c220af2_455313db : 64'd0);
        chk("imix_lat", 64'(lat), 64'd1);

        // Drop valid while in SUB: no ready may follow.
        op_vec = 7'(1 << OPI_ENCS);
        valid  = 1'b1;
        @(posedge g_clk);
        #1 valid = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge g_clk);
            if (ready) seen++;
        end
        chk("abort_sub_no_ready", 64'(seen), 64'd0);
        @(posedge g_clk);
        #1;
        run_op(OPI_ENCS, 64'd0, 64'd0, 4'd0, res, lat);
        chk("after_abort_lat", 64'(lat), 64'(N));

        // Drop valid during FIN: ready and rd forced low that cycle.
        op_vec = 7'(1 << OPI_ENCS);
        valid  = 1'b1;
        repeat (N) @(posedge g_clk);
        #1 valid = 1'b0;
        @(negedge g_clk);
        chk("abort_fin_ready", {63'd0, ready}, 64'd0);
        chk("abort_fin_rd", rd, 64'd0);
        @(posedge g_clk);
        #1;

        // Reset in the middle of SUB, then a clean restart.
        op_vec = 7'(1 << OPI_ENCSM);
        rs1    = 64'h0123456789abcdef;
        valid  = 1'b1;
        repeat (2) @(posedge g_clk);
        #1 g_resetn = 1'b0;
        #1;
        chk("reset_mid_ready", {63'd0, ready}, 64'd0);
        chk("reset_mid_rd", rd, 64'd0);
        valid  = 1'b0;
        op_vec = 7'd0;
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        run_op(OPI_ENCS, 64'd0, 64'd0, 4'd0, res, lat);
        chk("restart_encs", res, 64'h6363636363636363);
        chk("restart_lat", 64'(lat), 64'(N));

        // FIPS-197 AES-128: key 000102..0f, pt 00112233..ff.
        rk_lo[0] = 64'h0706050403020100;
        rk_hi[0] = 64'h0f0e0d0c0b0a0908;
        for (int r = 1; r <= 10; r++) begin
            run_op(OPI_KS1, rk_hi[r-1], 64'd0, 4'(r - 1), t, lat);
            idle_cycles($urandom_range(0, 2));
            run_op(OPI_KS2, t, swap(rk_lo[r-1]), 4'd0, lo, lat);
            run_op(OPI_KS2, lo, swap(rk_hi[r-1]), 4'd0, hi, lat);
            rk_lo[r] = lo;
            rk_hi[r] = hi;
        end
        chk("aes_rk10_lo", rk_lo[10], 64'h174a94e37f1d1113);
        chk("aes_rk10_hi", rk_hi[10], 64'hc5302b4d8ba707f3);

        s_lo = 64'h7766554433221100 ^ rk_lo[0];
        s_hi = 64'hffeeddccbbaa9988 ^ rk_hi[0];
        for (int r = 1; r <= 10; r++) begin
            run_op((r == 10) ? OPI_ENCS : OPI_ENCSM, s_lo, s_hi, 4'd0, d_lo, lat);
            idle_cycles($urandom_range(0, 2));
            run_op((r == 10) ? OPI_ENCS : OPI_ENCSM, s_hi, s_lo, 4'd0, d_hi, lat);
            s_lo = d_lo ^ rk_lo[r];
            s_hi = d_hi ^ rk_hi[r];
        end
        chk("aes_ct_lo", s_lo, 64'h30047b6ad8e0c469);
        chk("aes_ct_hi", s_hi, 64'h5ac5b47080b7cdd8);

        s_lo = 64'h30047b6ad8e0c469 ^ rk_lo[10];
        s_hi = 64'h5ac5b47080b7cdd8 ^ rk_hi[10];
        for (int r = 9; r >= 0; r--) begin
            run_op((r == 0) ? OPI_DECS : OPI_DECSM, s_lo, s_hi, 4'd0, d_lo, lat);
            run_op((r == 0) ? OPI_DECS : OPI_DECSM, s_hi, s_lo, 4'd0, d_hi, lat);
            idle_cycles($urandom_range(0, 2));
            if (r == 0) begin
                i_lo = rk_lo[0];
                i_hi = rk_hi[0];
            end else begin
                run_op(OPI_IMIX, rk_lo[r], 64'd0, 4'd0, i_lo, lat);
                run_op(OPI_IMIX, rk_hi[r], 64'd0, 4'd0, i_hi, lat);
            end
            s_lo = d_lo ^ i_lo;
            s_hi = d_hi ^ i_hi;
        end
        chk("aes_pt_lo", s_lo, DEC_EN ? 64'h7766554433221100 : s_lo ^ 64'd1);
        chk("aes_pt_hi", s_hi, DEC_EN ? 64'hffeeddccbbaa9988 : s_hi ^ 64'd1);

        idle_cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
